// File: rtl/nota_sequenciador.sv
// Note capture buffer and timed replay sequencer for a note classifier.
// Define TIMEOUT_EN to add the ESPERA timeout (TMO cycles) and the erro flag.
module nota_sequenciador #(
    parameter int PROF = 8,
    parameter int TMO  = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ok,
    input  logic [3:0] nota,
    input  logic       iniciar,
    output logic       cls_reset,
    output logic       cls_ok,
    output logic [3:0] cls_nota,
    input  logic       cls_fim,
    input  logic [1:0] cls_tipo,
    output logic       ocupado,
    output logic       pronto,
    output logic       cheio,
    output logic       erro,
    output logic [1:0] tipo,
    output logic [3:0] qtd
);

    localparam int IW = (PROF > 1) ? $clog2(PROF) : 1;
    localparam logic [3:0] PROF_L = 4'(PROF);

    typedef enum logic [2:0] {
        OCIOSO,
        LIMPA,
        ENVIA,
        ESPERA,
        CONCLUI
    } estado_t;

    typedef enum logic [1:0] {
        SETUP,
        PULSO,
        HOLD
    } fase_t;

    estado_t estado_q, estado_d;
    fase_t   fase_q, fase_d;

    logic [3:0]    idx_q, idx_d;
    logic [3:0]    qtd_q, qtd_d;
    logic [1:0]    tipo_q, tipo_d;
    logic [2:0]    sync_q;
    logic          ok_ev;

    logic [3:0]    mem_q [PROF];
    logic          wr_en;
    logic [IW-1:0] wr_addr;

    logic          cls_ok_q, cls_ok_d;
    logic [3:0]    cls_nota_q, cls_nota_d;
    logic          ocupado_q, ocupado_d;
    logic          pronto_q, pronto_d;

`ifdef TIMEOUT_EN
    localparam int CW = $clog2(TMO + 1);
    localparam logic [CW-1:0] TMO_M1 = CW'(TMO - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          erro_q, erro_d;
`endif

    // sync_q[2] is the previous synchronised level, used for edge detection
    assign ok_ev = sync_q[1] & ~sync_q[2];

    always_comb begin
        estado_d = estado_q;
        fase_d   = fase_q;
        idx_d    = idx_q;
        qtd_d    = qtd_q;
        tipo_d   = tipo_q;
        wr_en    = 1'b0;
        wr_addr  = qtd_q[IW-1:0];
`ifdef TIMEOUT_EN
        cnt_d    = '0;
        erro_d   = erro_q;
`endif
        unique case (estado_q)
            OCIOSO: begin
                if (iniciar && qtd_q != 4'd0) begin
                    estado_d = LIMPA;
                end else if (ok_ev && qtd_q < PROF_L) begin
                    wr_en = 1'b1;
                    qtd_d = qtd_q + 4'd1;
                end
            end
            LIMPA: begin
                estado_d = ENVIA;
                fase_d   = SETUP;
                idx_d    = 4'd0;
            end
            ENVIA: begin
                if (cls_fim) begin
                    tipo_d   = cls_tipo;
                    estado_d = CONCLUI;
                end else begin
                    unique case (fase_q)
                        SETUP: fase_d = PULSO;
                        PULSO: fase_d = HOLD;
                        HOLD: begin
                            if (idx_q == qtd_q - 4'd1) begin
                                estado_d = ESPERA;
                            end else begin
                                idx_d  = idx_q + 4'd1;
                                fase_d = SETUP;
                            end
                        end
                        default: fase_d = SETUP;
                    endcase
                end
            end
            ESPERA: begin
                if (cls_fim) begin
                    tipo_d   = cls_tipo;
                    estado_d = CONCLUI;
`ifdef TIMEOUT_EN
                end else if (cnt_q == TMO_M1) begin
                    tipo_d   = 2'b00;
                    erro_d   = 1'b1;
                    estado_d = CONCLUI;
                end else begin
                    cnt_d = cnt_q + 1'b1;
`endif
                end
            end
            CONCLUI: begin
                if (iniciar) begin
                    estado_d = LIMPA;
`ifdef TIMEOUT_EN
                    erro_d   = 1'b0;
`endif
                end else if (ok_ev) begin
                    wr_en    = 1'b1;
                    wr_addr  = '0;
                    qtd_d    = 4'd1;
                    estado_d = OCIOSO;
`ifdef TIMEOUT_EN
                    erro_d   = 1'b0;
`endif
                end
            end
            default: estado_d = OCIOSO;
        endcase
    end

    // Outputs are registered from next state so they align with estado_q
    always_comb begin
        cls_ok_d   = (estado_d == ENVIA) && (fase_d == PULSO);
        cls_nota_d = 4'd0;
        if (estado_d == ENVIA)
            cls_nota_d = mem_q[idx_d[IW-1:0]];
        ocupado_d  = (estado_d == LIMPA) || (estado_d == ENVIA) ||
                     (estado_d == ESPERA);
        pronto_d   = (estado_d == CONCLUI);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            estado_q   <= OCIOSO;
            fase_q     <= SETUP;
            idx_q      <= 4'd0;
            qtd_q      <= 4'd0;
            tipo_q     <= 2'b00;
            sync_q     <= 3'b000;
            cls_ok_q   <= 1'b0;
            cls_nota_q <= 4'd0;
            ocupado_q  <= 1'b0;
            pronto_q   <= 1'b0;
`ifdef TIMEOUT_EN
            cnt_q      <= '0;
            erro_q     <= 1'b0;
`endif
        end else begin
            estado_q   <= estado_d;
            fase_q     <= fase_d;
            idx_q      <= idx_d;
            qtd_q      <= qtd_d;
            tipo_q     <= tipo_d;
            sync_q     <= {sync_q[1:0], ok};
            cls_ok_q   <= cls_ok_d;
            cls_nota_q <= cls_nota_d;
            ocupado_q  <= ocupado_d;
            pronto_q   <= pronto_d;
`ifdef TIMEOUT_EN
            cnt_q      <= cnt_d;
            erro_q     <= erro_d;
`endif
        end
    end

    // Buffer contents are don't-care after reset, so no reset here
    always_ff @(posedge clk) begin
        if (wr_en)
            mem_q[wr_addr] <= nota;
    end

    assign cls_reset = reset | (estado_q == LIMPA);
    assign cls_ok    = cls_ok_q;
    assign cls_nota  = cls_nota_q;
    assign ocupado   = ocupado_q;
    assign pronto    = pronto_q;
    assign cheio     = (qtd_q == PROF_L);
    assign tipo      = tipo_q;
    assign qtd       = qtd_q;
`ifdef TIMEOUT_EN
    assign erro      = erro_q;
`else
    assign erro      = 1'b0;
`endif

endmodule

// File: tb/tb_nota_sequenciador.sv
// Bench for nota_sequenciador: note-list model, stand-in classifier,
// per-cycle pulse monitor and directed scenarios.
module tb_nota_sequenciador;

    localparam int PROF = 8;
    localparam int TMO  = 16;

    logic       clk = 1'b0;
    logic       reset;
    logic       ok;
    logic [3:0] nota;
    logic       iniciar;
    logic       cls_reset;
    logic       cls_ok;
    logic [3:0] cls_nota;
    logic       cls_fim;
    logic [1:0] cls_tipo;
    logic       ocupado;
    logic       pronto;
    logic       cheio;
    logic       erro;
    logic [1:0] tipo;
    logic [3:0] qtd;

    int total = 0;
    int bad   = 0;

    nota_sequenciador #(.PROF(PROF), .TMO(TMO)) dut (
        .clk      (clk),
        .reset    (reset),
        .ok       (ok),
        .nota     (nota),
        .iniciar  (iniciar),
        .cls_reset(cls_reset),
        .cls_ok   (cls_ok),
        .cls_nota (cls_nota),
        .cls_fim  (cls_fim),
        .cls_tipo (cls_tipo),
        .ocupado  (ocupado),
        .pronto   (pronto),
        .cheio    (cheio),
        .erro     (erro),
        .tipo     (tipo),
        .qtd      (qtd)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=%0d want=%0d t=%0t", nm, got, want, $time);
        end
    endtask

    // Stand-in classifier: a 0 note ends the word one cycle after its HOLD
    logic c_pend, c_seen, c_first0, c_has6, c_has15;
    always @(posedge clk or posedge cls_reset) begin
        if (cls_reset) begin
            cls_fim  <= 1'b0;
            cls_tipo <= 2'b00;
            c_pend   <= 1'b0;
            c_seen   <= 1'b0;
            c_first0 <= 1'b0;
            c_has6   <= 1'b0;
            c_has15  <= 1'b0;
        end else begin
            if (c_pend) begin
                cls_fim  <= 1'b1;
                cls_tipo <= c_first0 ? 2'b00 :
                            (c_has15 && c_has6) ? 2'b11 :
                            c_has15 ? 2'b10 : 2'b01;
                c_pend   <= 1'b0;
            end
            if (cls_ok) begin
                if (!c_seen) c_first0 <= (cls_nota == 4'd0);
                c_seen <= 1'b1;
                if (cls_nota == 4'd6)  c_has6  <= 1'b1;
                if (cls_nota == 4'd15) c_has15 <= 1'b1;
                if (cls_nota == 4'd0)  c_pend  <= 1'b1;
            end
        end
    end

    // Model: the captured note list and the expected replay stream
    logic [3:0] notes[$];
    logic [3:0] exp_q[$];
    bit         concl = 0;

    function automatic logic [1:0] classify();
        bit h6 = 0;
        bit h15 = 0;
        if (notes.size() == 0 || notes[0] == 4'd0) return 2'b00;
        foreach (notes[k]) begin
            if (notes[k] == 4'd0) break;
            if (notes[k] == 4'd6)  h6  = 1;
            if (notes[k] == 4'd15) h15 = 1;
        end
        if (h15 && h6) return 2'b11;
        if (h15) return 2'b10;
        return 2'b01;
    endfunction

    // Monitor: pulse contents, spacing and SETUP/HOLD stability
    int         exp_idx = 0;
    int         cyc = 0;
    int         last_p = -1;
    bit         hold_chk = 0;
    logic [3:0] hold_nota = 4'd0;
    logic [3:0] prev_nota = 4'd0;

    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (cls_reset) begin
                exp_idx  = 0;
                last_p   = -1;
                hold_chk = 0;
            end else begin
                if (hold_chk) begin
                    chk("hold_ok", cls_ok, 0);
                    chk("hold_nota", cls_nota, hold_nota);
                    hold_chk = 0;
                end
                if (cls_ok) begin
                    chk("pulse_busy", ocupado, 1);
                    chk("setup_nota", cls_nota, prev_nota);
                    if (exp_idx < exp_q.size())
                        chk("pulse_nota", cls_nota, exp_q[exp_idx]);
                    else
                        chk("extra_pulse", exp_idx, exp_q.size());
                    if (last_p >= 0)
                        chk("pulse_gap", cyc - last_p, 3);
                    last_p    = cyc;
                    exp_idx++;
                    hold_chk  = 1;
                    hold_nota = cls_nota;
                end
                if (!ocupado && !pronto)
                    chk("cheio", cheio, qtd == 4'(PROF));
            end
            prev_nota = cls_nota;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic enter(input logic [3:0] n);
        nota = n;
        ok   = 1'b1;
        tick(4);
        ok   = 1'b0;
        tick(4);
        if (concl) begin
            notes.delete();
            notes.push_back(n);
            concl = 0;
        end else if (notes.size() < PROF) begin
            notes.push_back(n);
        end
        chk("qtd", qtd, notes.size());
        chk("pronto_clr", pronto, 0);
    endtask

    task automatic load_exp();
        exp_q.delete();
        foreach (notes[k]) begin
            exp_q.push_back(notes[k]);
            if (notes[k] == 4'd0) break;
        end
    endtask

    task automatic replay(input bit coinc, input logic [3:0] cn,
                          output int busy);
        bit got = 0;
        load_exp();
        busy = 0;
        if (coinc) begin
            nota = cn;
            ok   = 1'b1;
            tick(2);
        end
        iniciar = 1'b1;
        for (int k = 0; k < 300 && !got; k++) begin
            @(negedge clk);
            iniciar = 1'b0;
            if (ocupado) busy++;
            if (pronto) got = 1;
        end
        ok = 1'b0;
        chk("done_in_time", got, 1);
        chk("ocupado_end", ocupado, 0);
        chk("tipo", tipo, classify());
        chk("pulses", exp_idx, exp_q.size());
        chk("erro0", erro, 0);
        chk("qtd_kept", qtd, notes.size());
        concl = 1;
        tick(4);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int busy;
        int seen;
        int first;
        reset   = 1'b1;
        ok      = 1'b0;
        iniciar = 1'b0;
        nota    = 4'd0;
        tick(3);
        chk("rst_qtd", qtd, 0);
        chk("rst_pronto", pronto, 0);
        chk("rst_ocupado", ocupado, 0);
        chk("rst_cheio", cheio, 0);
        chk("rst_erro", erro, 0);
        chk("rst_tipo", tipo, 0);
        chk("rst_cls_ok", cls_ok, 0);
        chk("rst_cls_nota", cls_nota, 0);
        chk("rst_cls_reset", cls_reset, 1);
        reset = 1'b0;
        tick(2);
        chk("idle_cls_reset", cls_reset, 0);

        iniciar = 1'b1;
        tick(1);
        iniciar = 1'b0;
        tick(3);
        chk("empty_start_ign", ocupado, 0);
        chk("empty_start_qtd", qtd, 0);

        enter(1); enter(2); enter(6); enter(0);
        replay(1'b1, 4'd9, busy);
        chk("adj_tipo_lit", tipo, 2'b01);
        chk("adj_pronto", pronto, 1);
        chk("adj_busy_lit", busy, 14);
        chk("adj_pulses_lit", exp_idx, 4);
        chk("coinc_qtd_lit", qtd, 4);

        enter(1); enter(2); enter(15); enter(2); enter(0);
        replay(1'b0, 4'd0, busy);
        chk("t10_lit", tipo, 2'b10);
        chk("t10_busy", busy, 3 * 5 + 2);
        replay(1'b0, 4'd0, busy);
        chk("t10_again_lit", tipo, 2'b10);
        chk("t10_again_busy", busy, 17);

        enter(1); enter(2); enter(6); enter(15); enter(0);
        replay(1'b0, 4'd0, busy);
        chk("t11_lit", tipo, 2'b11);

        for (int v = 3; v <= 9; v++) enter(4'(v));
        enter(0);
        enter(12);
        chk("full_qtd_lit", qtd, 8);
        chk("full_cheio_lit", cheio, 1);
        replay(1'b0, 4'd0, busy);
        chk("full_busy", busy, 3 * PROF + 2);

        enter(0); enter(5); enter(6);
        replay(1'b0, 4'd0, busy);
        chk("abort_tipo_lit", tipo, 2'b00);
        chk("abort_pronto", pronto, 1);
        chk("abort_busy_lit", busy, 5);
        chk("abort_pulses_lit", exp_idx, 1);
        tick(10);

        enter(1); enter(2); enter(0);
        load_exp();
        seen = 0;
        iniciar = 1'b1;
        for (int k = 0; k < 50 && seen < 2; k++) begin
            @(negedge clk);
            iniciar = 1'b0;
            if (cls_ok) seen++;
        end
        chk("second_pulse_seen", seen, 2);
        #1;
        reset = 1'b1;
        exp_q.delete();
        #1;
        chk("mid_rst_cls_ok", cls_ok, 0);
        chk("mid_rst_qtd", qtd, 0);
        chk("mid_rst_cls_reset", cls_reset, 1);
        chk("mid_rst_ocupado", ocupado, 0);
        tick(2);
        reset = 1'b0;
        notes.delete();
        concl = 0;
        tick(20);
        chk("post_rst_ocupado", ocupado, 0);
        chk("post_rst_qtd", qtd, 0);

        enter(1); enter(2); enter(3);
        load_exp();
        first = -1;
        iniciar = 1'b1;
        for (int k = 0; k < 3 * 3 + 1 + TMO + 10 && first < 0; k++) begin
            @(negedge clk);
            iniciar = 1'b0;
            if (erro === 1'b1) first = k;
        end
        chk("wait_pulses", exp_idx, 3);
`ifdef TIMEOUT_EN
        chk("tmo_when", first, 3 * 3 + 1 + TMO);
        chk("tmo_pronto", pronto, 1);
        chk("tmo_tipo", tipo, 2'b00);
        concl = 1;
        enter(4);
        chk("tmo_erro_clr", erro, 0);
`else
        chk("no_tmo_erro", first, -1);
        chk("no_tmo_busy", ocupado, 1);
        chk("no_tmo_pronto", pronto, 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/nota_sequenciador.md
NOTA_SEQUENCIADOR -- requirements
Module: nota_sequenciador

Interface
REQ-001 SHALL have parameter PROF, default 8, meaning note-buffer depth (2..15).
REQ-002 SHALL have parameter TMO, default 16, meaning the fim-wait timeout in clk cycles (used only under REQ-030).
REQ-003 SHALL have port clk, input, 1 bit: single clock, all logic on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port ok, input, 1 bit: user confirm button, asynchronous level.
REQ-006 SHALL have port nota, input, 4 bits: note code to capture.
REQ-007 SHALL have port iniciar, input, 1 bit: start replay; synchronous level, sampled each cycle.
REQ-008 SHALL have outputs cls_reset, cls_ok (1 bit each) and cls_nota (4 bits), driving the classifier's reset, ok and nota.
REQ-009 SHALL have inputs cls_fim (1 bit) and cls_tipo (2 bits), returned from the classifier.
REQ-010 SHALL have outputs ocupado (1), pronto (1), cheio (1), erro (1), tipo (2) and qtd (4).

Function
REQ-011 SHALL synchronise ok through 2 flops; an ok event is a 0->1 transition of the synchronised signal.
REQ-012 SHALL implement states OCIOSO, LIMPA, ENVIA, ESPERA and CONCLUI.
REQ-013 In OCIOSO, an ok event with qtd<PROF SHALL write nota to buf[qtd] and increment qtd in the same edge.
REQ-014 In OCIOSO with qtd==PROF, cheio SHALL be 1 and further ok events SHALL be ignored.
REQ-015 In OCIOSO, iniciar=1 with qtd>0 SHALL go to LIMPA; iniciar=1 with qtd==0 SHALL be ignored.
REQ-016 If iniciar=1 and an ok event coincide in OCIOSO, iniciar SHALL win and the note SHALL be discarded.
REQ-017 LIMPA SHALL last exactly 1 cycle with cls_reset=1, then go to ENVIA with index i=0.
REQ-018 In ENVIA, each note SHALL take 3 cycles: SETUP (cls_nota=buf[i], cls_ok=0), PULSO (cls_ok=1), HOLD (cls_ok=0); cls_nota SHALL stay stable over all 3 cycles.
REQ-019 After the HOLD of i==qtd-1, ENVIA SHALL go to ESPERA; the replay of N notes SHALL take 3N cycles.
REQ-020 In ESPERA, cls_fim=1 SHALL latch tipo<=cls_tipo and go to CONCLUI.
REQ-021 If cls_fim rises during ENVIA (early error), the block SHALL latch tipo, abort the remaining notes and go to CONCLUI.
REQ-022 In CONCLUI, pronto SHALL be 1 and tipo SHALL be held.
REQ-023 In CONCLUI, iniciar=1 SHALL replay the same buffer via LIMPA.
REQ-024 In CONCLUI, an ok event SHALL set qtd<=1 with buf[0]<=nota, clear pronto and go to OCIOSO.
REQ-025 ocupado SHALL be 1 in LIMPA, ENVIA and ESPERA, and 0 otherwise.
REQ-026 ok events outside OCIOSO and CONCLUI SHALL be ignored.
REQ-027 cls_reset SHALL equal reset OR (state==LIMPA).

Reset
REQ-028 reset=1 SHALL immediately force:
- state=OCIOSO; qtd=0; i=0;
- tipo=00; pronto=ocupado=cheio=erro=0;
- cls_ok=0; cls_nota=0; cls_reset=1;
- synchroniser flops=0.
REQ-029 Reset mid-replay SHALL abort with no further cls_ok pulses; buffer contents are don't-care.

Configuration
REQ-030 With TIMEOUT_EN defined, ESPERA SHALL count cycles, and after TMO cycles without cls_fim SHALL set erro=1 and tipo=00 and go to CONCLUI; erro SHALL clear on leaving CONCLUI.
REQ-031 Without TIMEOUT_EN, ESPERA SHALL wait indefinitely and erro SHALL be tied to 0.

Verification
REQ-032 Enter notes 1,2,6,0 via ok, then iniciar -> 12 cycles of cls_ok pulses, classifier adjective -> pronto=1, tipo=01.
REQ-033 Enter notes 1,2,15,2,0, then iniciar -> tipo=10; then iniciar again -> identical replay, tipo=10.
REQ-034 Enter notes 1,2,6,15,0, then iniciar -> tipo=11; enter PROF+1 notes -> qtd=PROF, cheio=1, last note dropped.
REQ-035 First note 0 -> classifier cls_fim during ENVIA -> abort, tipo=00, pronto=1, no further cls_ok pulses.
REQ-036 Assert reset during the PULSO cycle of note 2 -> cls_ok=0 and qtd=0 in the same cycle, cls_reset=1; with TIMEOUT_EN and cls_fim held 0 -> erro=1 exactly TMO cycles after ESPERA entry.
